// File: rtl/mem_stage_controller.sv
// -----------------------------------------------------------------------------
// mem_stage_controller
//   Sequences data-cache accesses for the MEM stage of the LC-3b pipeline.
//   Single-access ops: LDR, STR, LDB, STB.  Two-access ops: LDI, STI, where
//   the first read fetches a pointer and the second access uses it.
//   Builds byte enables and aligned load data, and generates the MEM/WB load
//   strobe, the MEM/WB bubble request and a stall to every upstream stage.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   valid_in, opcode    EX/MEM instruction qualifier and lc3b opcode
//   flush               squash the instruction currently in MEM
//   addr_in, wdata_in   effective address and store data from EX/MEM
//   dcache_*            data-cache request (read/write/address/wdata/byte
//                       enable) and response (resp/rdata)
//   mem_rdata_out       load result to MEM/WB (held between loads)
//   load_mem_wb         MEM/WB register load enable
//   kill_out            MEM/WB must capture a bubble
//   stall               freeze PC, IF/ID, ID/EX, EX/MEM
//
// Optional feature macro: MEM_STALL_PERF_EN
//   Adds saturating counters stall_cycles and mem_ops (STALL_CNT_W bits).
// -----------------------------------------------------------------------------
module mem_stage_controller #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [3:0]  opcode,
  input  logic        flush,
  input  logic [15:0] addr_in,
  input  logic [15:0] wdata_in,
  input  logic        dcache_resp,
  input  logic [15:0] dcache_rdata,
  output logic        dcache_read,
  output logic        dcache_write,
  output logic [15:0] dcache_address,
  output logic [15:0] dcache_wdata,
  output logic [1:0]  dcache_byte_enable,
  output logic [15:0] mem_rdata_out,
  output logic        load_mem_wb,
  output logic        kill_out,
  output logic        stall
`ifdef MEM_STALL_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [STALL_CNT_W-1:0] mem_ops
`endif
);

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  if (STALL_CNT_W < 1) begin : g_bad_width
    $error("STALL_CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_INDIRECT,
    S_COMMIT
  } state_e;

  state_e      state_q;
  logic [3:0]  op_q;
  logic        flush_q;
  logic        byte_hi_q;
  logic        read_q;
  logic        write_q;
  logic [15:0] addr_q;     // also holds the LDI/STI pointer during INDIRECT
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic [15:0] rdata_q;

  logic is_mem_op;
  logic accept;
  logic pass;

  always_comb begin
    is_mem_op = 1'b0;
    case (opcode)
      OP_LDB, OP_STB, OP_LDR, OP_STR, OP_LDI, OP_STI: is_mem_op = 1'b1;
      default:                                        is_mem_op = 1'b0;
    endcase
  end

  assign accept = (state_q == S_IDLE) && valid_in &&  is_mem_op;
  assign pass   = (state_q == S_IDLE) && valid_in && !is_mem_op;

  // Pipeline handshakes are combinational on the IDLE inputs so non-memory
  // ops flow through with no bubble; reset_n gates them so every output is
  // low while reset is held.
  assign load_mem_wb = reset_n && (pass || (state_q == S_COMMIT));
  assign stall       = reset_n && (accept || (state_q == S_ACCESS) ||
                                   (state_q == S_INDIRECT));
  assign kill_out    = reset_n && ((pass && flush) ||
                                   ((state_q == S_COMMIT) && (flush_q || flush)));

  assign dcache_read        = read_q;
  assign dcache_write       = write_q;
  assign dcache_address     = addr_q;
  assign dcache_wdata       = wdata_q;
  assign dcache_byte_enable = be_q;
  assign mem_rdata_out      = rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      flush_q   <= 1'b0;
      byte_hi_q <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q   <= S_ACCESS;
            op_q      <= opcode;
            flush_q   <= flush;
            byte_hi_q <= addr_in[0];
            case (opcode)
              OP_LDB: begin
                read_q  <= 1'b1;
                write_q <= 1'b0;
                addr_q  <= addr_in;
                be_q    <= 2'b11;
                wdata_q <= '0;
              end
              OP_STB: begin
                read_q  <= 1'b0;
                write_q <= 1'b1;
                addr_q  <= addr_in;
                be_q    <= addr_in[0] ? 2'b10 : 2'b01;
                wdata_q <= {wdata_in[7:0], wdata_in[7:0]};
              end
              OP_STR: begin
                read_q  <= 1'b0;
                write_q <= 1'b1;
                addr_q  <= {addr_in[15:1], 1'b0};
                be_q    <= 2'b11;
                wdata_q <= wdata_in;
              end
              OP_STI: begin
                // Pointer fetch is a read; store data waits for INDIRECT.
                read_q  <= 1'b1;
                write_q <= 1'b0;
                addr_q  <= {addr_in[15:1], 1'b0};
                be_q    <= 2'b11;
                wdata_q <= wdata_in;
              end
              default: begin // LDR, LDI
                read_q  <= 1'b1;
                write_q <= 1'b0;
                addr_q  <= {addr_in[15:1], 1'b0};
                be_q    <= 2'b11;
                wdata_q <= '0;
              end
            endcase
          end
        end

        S_ACCESS: begin
          flush_q <= flush_q || flush;
          if (dcache_resp) begin
            if ((op_q == OP_LDI) || (op_q == OP_STI)) begin
              state_q <= S_INDIRECT;
              addr_q  <= {dcache_rdata[15:1], 1'b0};
              read_q  <= (op_q == OP_LDI);
              write_q <= (op_q == OP_STI);
              be_q    <= 2'b11;
            end else begin
              state_q <= S_COMMIT;
              read_q  <= 1'b0;
              write_q <= 1'b0;
              addr_q  <= '0;
              wdata_q <= '0;
              be_q    <= '0;
              if (op_q == OP_LDB) begin
                rdata_q <= byte_hi_q ? {8'h00, dcache_rdata[15:8]}
                                     : {8'h00, dcache_rdata[7:0]};
              end else if (op_q == OP_LDR) begin
                rdata_q <= dcache_rdata;
              end
            end
          end
        end

        S_INDIRECT: begin
          flush_q <= flush_q || flush;
          if (dcache_resp) begin
            state_q <= S_COMMIT;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            if (op_q == OP_LDI) begin
              rdata_q <= dcache_rdata;
            end
          end
        end

        S_COMMIT: begin
          state_q <= S_IDLE;
          flush_q <= 1'b0;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_STALL_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      mem_ops      <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
      if ((state_q == S_COMMIT) && (mem_ops != '1)) begin
        mem_ops <= mem_ops + STALL_CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_controller.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_controller
//   Directed bench for mem_stage_controller.  Inputs change 2 time units after
//   each rising edge; outputs are checked 1 unit later, well clear of the edge.
// -----------------------------------------------------------------------------
module tb_mem_stage_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [3:0]  opcode;
  logic        flush;
  logic [15:0] addr_in;
  logic [15:0] wdata_in;
  logic        dcache_resp;
  logic [15:0] dcache_rdata;
  logic        dcache_read;
  logic        dcache_write;
  logic [15:0] dcache_address;
  logic [15:0] dcache_wdata;
  logic [1:0]  dcache_byte_enable;
  logic [15:0] mem_rdata_out;
  logic        load_mem_wb;
  logic        kill_out;
  logic        stall;
`ifdef MEM_STALL_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] mem_ops;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  mem_stage_controller #(.STALL_CNT_W(16)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .valid_in           (valid_in),
    .opcode             (opcode),
    .flush              (flush),
    .addr_in            (addr_in),
    .wdata_in           (wdata_in),
    .dcache_resp        (dcache_resp),
    .dcache_rdata       (dcache_rdata),
    .dcache_read        (dcache_read),
    .dcache_write       (dcache_write),
    .dcache_address     (dcache_address),
    .dcache_wdata       (dcache_wdata),
    .dcache_byte_enable (dcache_byte_enable),
    .mem_rdata_out      (mem_rdata_out),
    .load_mem_wb        (load_mem_wb),
    .kill_out           (kill_out),
    .stall              (stall)
`ifdef MEM_STALL_PERF_EN
    ,
    .stall_cycles       (stall_cycles),
    .mem_ops            (mem_ops)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Present a memory op in IDLE, check the accept-cycle handshake, clock it
  // in, then withdraw valid_in.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] w,
                       input string tag);
    valid_in = 1'b1;
    opcode   = op;
    addr_in  = a;
    wdata_in = w;
    settle();
    chk({tag, " accept stall"}, 16'(stall), 16'd1);
    chk({tag, " accept load"},  16'(load_mem_wb), 16'd0);
    step();
    valid_in = 1'b0;
    opcode   = 4'b0000;
    addr_in  = 16'hFFFF;
    wdata_in = 16'hFFFF;
  endtask

  initial begin
    reset_n      = 1'b0;
    valid_in     = 1'b1;
    opcode       = 4'b0001;
    flush        = 1'b0;
    addr_in      = '0;
    wdata_in     = '0;
    dcache_resp  = 1'b0;
    dcache_rdata = '0;
    #3;
    // Reset: every output low even with a pass-through op presented
    chk("rst read",  16'(dcache_read), 16'd0);
    chk("rst write", 16'(dcache_write), 16'd0);
    chk("rst addr",  dcache_address, 16'h0000);
    chk("rst rdata", mem_rdata_out, 16'h0000);
    chk("rst load",  16'(load_mem_wb), 16'd0);
    chk("rst stall", 16'(stall), 16'd0);
    chk("rst kill",  16'(kill_out), 16'd0);
    #9 reset_n = 1'b1;
    step();

    // ADD passes straight through in IDLE
    valid_in = 1'b1;
    opcode   = 4'b0001;
    settle();
    chk("add load",  16'(load_mem_wb), 16'd1);
    chk("add stall", 16'(stall), 16'd0);
    chk("add read",  16'(dcache_read), 16'd0);
    chk("add write", 16'(dcache_write), 16'd0);
    chk("add kill",  16'(kill_out), 16'd0);
    flush = 1'b1;
    settle();
    chk("add flush kill", 16'(kill_out), 16'd1);
    flush = 1'b0;
    step();

    // LDR 0x3005, resp on second ACCESS cycle
    issue(4'b0110, 16'h3005, 16'h0000, "ldr");
    settle();
    chk("ldr acc1 read",  16'(dcache_read), 16'd1);
    chk("ldr acc1 write", 16'(dcache_write), 16'd0);
    chk("ldr acc1 addr",  dcache_address, 16'h3004);
    chk("ldr acc1 be",    16'(dcache_byte_enable), 16'h0003);
    chk("ldr acc1 stall", 16'(stall), 16'd1);
    chk("ldr acc1 load",  16'(load_mem_wb), 16'd0);
    step();
    dcache_resp  = 1'b1;
    dcache_rdata = 16'hBEEF;
    settle();
    chk("ldr acc2 read",  16'(dcache_read), 16'd1);
    chk("ldr acc2 addr",  dcache_address, 16'h3004);
    chk("ldr acc2 stall", 16'(stall), 16'd1);
    step();
    // resp left high through COMMIT and IDLE: must be ignored there
    dcache_rdata = 16'h1111;
    settle();
    chk("ldr cmt load",  16'(load_mem_wb), 16'd1);
    chk("ldr cmt stall", 16'(stall), 16'd0);
    chk("ldr cmt read",  16'(dcache_read), 16'd0);
    chk("ldr cmt addr",  dcache_address, 16'h0000);
    chk("ldr cmt be",    16'(dcache_byte_enable), 16'h0000);
    chk("ldr cmt rdata", mem_rdata_out, 16'hBEEF);
    chk("ldr cmt kill",  16'(kill_out), 16'd0);
    step();
    settle();
    chk("ldr idle load",  16'(load_mem_wb), 16'd0);
    chk("ldr idle stall", 16'(stall), 16'd0);
    chk("ldr idle read",  16'(dcache_read), 16'd0);
    step();
    settle();
    chk("idle resp ign read",  16'(dcache_read), 16'd0);
    chk("idle resp ign rdata", mem_rdata_out, 16'hBEEF);
    dcache_resp = 1'b0;

    // LDB 0x2001, resp on first ACCESS cycle -> high byte
    issue(4'b0010, 16'h2001, 16'h0000, "ldb");
    dcache_resp  = 1'b1;
    dcache_rdata = 16'hA55A;
    settle();
    chk("ldb read", 16'(dcache_read), 16'd1);
    chk("ldb addr", dcache_address, 16'h2001);
    chk("ldb be",   16'(dcache_byte_enable), 16'h0003);
    step();
    dcache_resp = 1'b0;
    settle();
    chk("ldb cmt load",  16'(load_mem_wb), 16'd1);
    chk("ldb cmt rdata", mem_rdata_out, 16'h00A5);
    step();

    // LDB 0x2000 -> low byte
    issue(4'b0010, 16'h2000, 16'h0000, "ldb0");
    dcache_resp  = 1'b1;
    dcache_rdata = 16'hA55A;
    step();
    dcache_resp = 1'b0;
    settle();
    chk("ldb0 cmt rdata", mem_rdata_out, 16'h005A);
    step();

    // STB 0x2000 / 0x2001
    issue(4'b0011, 16'h2000, 16'h1234, "stb0");
    dcache_resp = 1'b1;
    settle();
    chk("stb0 write", 16'(dcache_write), 16'd1);
    chk("stb0 read",  16'(dcache_read), 16'd0);
    chk("stb0 addr",  dcache_address, 16'h2000);
    chk("stb0 be",    16'(dcache_byte_enable), 16'h0001);
    chk("stb0 wdata", dcache_wdata, 16'h3434);
    step();
    dcache_resp = 1'b0;
    settle();
    chk("stb0 cmt load",  16'(load_mem_wb), 16'd1);
    chk("stb0 cmt rdata", mem_rdata_out, 16'h005A);
    chk("stb0 cmt wdata", dcache_wdata, 16'h0000);
    chk("stb0 cmt write", 16'(dcache_write), 16'd0);
    step();
    issue(4'b0011, 16'h2001, 16'h12AB, "stb1");
    dcache_resp = 1'b1;
    settle();
    chk("stb1 be",    16'(dcache_byte_enable), 16'h0002);
    chk("stb1 wdata", dcache_wdata, 16'hABAB);
    step();
    dcache_resp = 1'b0;
    step();

    // STR 0x3007 -> word aligned write
    issue(4'b0111, 16'h3007, 16'h9876, "str");
    dcache_resp = 1'b1;
    settle();
    chk("str write", 16'(dcache_write), 16'd1);
    chk("str addr",  dcache_address, 16'h3006);
    chk("str be",    16'(dcache_byte_enable), 16'h0003);
    chk("str wdata", dcache_wdata, 16'h9876);
    step();
    dcache_resp = 1'b0;
    step();

    // STI 0x4000, pointer 0x5002, data 0xCAFE
    issue(4'b1011, 16'h4000, 16'hCAFE, "sti");
    settle();
    chk("sti acc read",  16'(dcache_read), 16'd1);
    chk("sti acc write", 16'(dcache_write), 16'd0);
    chk("sti acc addr",  dcache_address, 16'h4000);
    step();
    dcache_resp  = 1'b1;
    dcache_rdata = 16'h5002;
    step();
    dcache_resp  = 1'b0;
    dcache_rdata = 16'h0000;
    settle();
    chk("sti ind write", 16'(dcache_write), 16'd1);
    chk("sti ind read",  16'(dcache_read), 16'd0);
    chk("sti ind addr",  dcache_address, 16'h5002);
    chk("sti ind be",    16'(dcache_byte_enable), 16'h0003);
    chk("sti ind wdata", dcache_wdata, 16'hCAFE);
    chk("sti ind stall", 16'(stall), 16'd1);
    chk("sti ind load",  16'(load_mem_wb), 16'd0);
    step();
    dcache_resp = 1'b1;
    settle();
    chk("sti ind2 load", 16'(load_mem_wb), 16'd0);
    step();
    dcache_resp = 1'b0;
    settle();
    chk("sti cmt load",  16'(load_mem_wb), 16'd1);
    chk("sti cmt write", 16'(dcache_write), 16'd0);
    chk("sti cmt rdata", mem_rdata_out, 16'h005A);
    step();
    settle();
    chk("sti idle load", 16'(load_mem_wb), 16'd0);

    // LDI 0x1000, odd pointer 0x6001, flush during INDIRECT
    issue(4'b1010, 16'h1000, 16'h0000, "ldi");
    dcache_resp  = 1'b1;
    dcache_rdata = 16'h6001;
    settle();
    chk("ldi acc addr", dcache_address, 16'h1000);
    step();
    dcache_resp = 1'b0;
    flush       = 1'b1;
    settle();
    chk("ldi ind read",  16'(dcache_read), 16'd1);
    chk("ldi ind addr",  dcache_address, 16'h6000);
    chk("ldi ind kill",  16'(kill_out), 16'd0);
    step();
    flush        = 1'b0;
    dcache_resp  = 1'b1;
    dcache_rdata = 16'h7777;
    settle();
    chk("ldi ind2 read", 16'(dcache_read), 16'd1);
    step();
    dcache_resp = 1'b0;
    settle();
    chk("ldi cmt kill",  16'(kill_out), 16'd1);
    chk("ldi cmt load",  16'(load_mem_wb), 16'd1);
    chk("ldi cmt rdata", mem_rdata_out, 16'h7777);
    step();
    settle();
    chk("ldi idle kill", 16'(kill_out), 16'd0);

    // Reset mid-access
    issue(4'b0110, 16'h0100, 16'h0000, "rstmid");
    settle();
    chk("rstmid read before", 16'(dcache_read), 16'd1);
    reset_n = 1'b0;
    settle();
    chk("rstmid read",  16'(dcache_read), 16'd0);
    chk("rstmid addr",  dcache_address, 16'h0000);
    chk("rstmid stall", 16'(stall), 16'd0);
    chk("rstmid rdata", mem_rdata_out, 16'h0000);
    #1 reset_n = 1'b1;
    step();
    settle();
    chk("rstmid post stall", 16'(stall), 16'd0);
    chk("rstmid post read",  16'(dcache_read), 16'd0);
    valid_in = 1'b1;
    opcode   = 4'b0101;
    settle();
    chk("rstmid post pass load", 16'(load_mem_wb), 16'd1);
    valid_in = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
